// File: rtl/bof_range_arbiter.sv
// Two-requester round-robin arbiter that loads granted address intervals into
// a small circular table, with a one-cycle registered range lookup.
module bof_range_arbiter #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clr_i,
   input  logic [1:0]                 req_i,
   input  logic [AW-1:0]              start0_i,
   input  logic [AW-1:0]              end0_i,
   input  logic [AW-1:0]              start1_i,
   input  logic [AW-1:0]              end1_i,
   output logic [1:0]                 gnt_o,
   output logic                       err_o,
   input  logic                       lookup_valid_i,
   input  logic [AW-1:0]              lookup_addr_i,
   output logic                       lookup_valid_o,
   output logic                       hit_o,
   output logic                       hit_first_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // Table storage
   logic [AW-1:0] r_start [DEPTH];
   logic [AW-1:0] r_end   [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             r_prio;
   logic             r_err;
   logic             r_lkv;
   logic             r_hit;
   logic             r_hit_first;

   logic [1:0]    w_gnt;
   logic [AW-1:0] w_start;
   logic [AW-1:0] w_end;
   logic          w_bad;
   logic          w_dup;
   logic          w_write;
   logic          w_hit;
   logic          w_hit_first;
   logic          w_full;

   // Round-robin grant; suppressed while in reset or clearing
   always_comb begin
      w_gnt = 2'b00;
      if (rst_ni && !clr_i) begin
         unique case (req_i)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   // Select granted interval and classify it as invalid, duplicate or writable
   always_comb begin
      w_start = w_gnt[1] ? start1_i : start0_i;
      w_end   = w_gnt[1] ? end1_i   : end0_i;
      w_bad   = w_start > w_end;
      w_dup   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_start[i] == w_start) && (r_end[i] == w_end)) begin
            w_dup = 1'b1;
         end
      end
      w_write = (|w_gnt) && !w_bad && !w_dup;
   end

   // Range match against the table as it stands before this edge
   always_comb begin
      w_hit       = 1'b0;
      w_hit_first = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (lookup_addr_i >= r_start[i]) && (lookup_addr_i <= r_end[i])) begin
            w_hit = 1'b1;
            if (lookup_addr_i == r_start[i]) begin
               w_hit_first = 1'b1;
            end
         end
      end
   end

   assign w_full = (r_count == CW'(DEPTH));

   // Control state: valid bits, pointers, count, priority, error and lookup results
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid     <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_prio      <= 1'b0;
         r_err       <= 1'b0;
         r_lkv       <= 1'b0;
         r_hit       <= 1'b0;
         r_hit_first <= 1'b0;
      end else begin
         r_err       <= (|w_gnt) && w_bad;
         r_lkv       <= lookup_valid_i;
         r_hit       <= lookup_valid_i && w_hit;
         r_hit_first <= lookup_valid_i && w_hit_first;
         // Pointer always moves away from whoever was granted, even if nothing is written
         if (w_gnt[0]) begin
            r_prio <= 1'b1;
         end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
         end
         if (clr_i) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else if (w_write) begin
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + PW'(1);
            if (!w_full) begin
               r_count <= r_count + CW'(1);
            end
         end
      end
   end

   // Interval bounds need no reset; validity is tracked separately
   always_ff @(posedge clk_i) begin
      if (w_write && !clr_i) begin
         r_start[r_wr_ptr] <= w_start;
         r_end[r_wr_ptr]   <= w_end;
      end
   end

   assign gnt_o          = w_gnt;
   assign err_o          = r_err;
   assign lookup_valid_o = r_lkv;
   assign hit_o          = r_hit;
   assign hit_first_o    = r_hit_first;
   assign count_o        = r_count;
   assign full_o         = w_full;

endmodule

// File: doc/bof_range_arbiter.md
BOF_RANGE_ARBITER -- requirements
Module: bof_range_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of interval entries (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_ni  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 clr_i  input  1  synchronous table clear.
REQ-006 req_i  input  2  interval write request per requester (bit k = requester k).
REQ-007 start0_i, end0_i  input  AW each  requester 0 interval, inclusive bounds.
REQ-008 start1_i, end1_i  input  AW each  requester 1 interval, inclusive bounds.
REQ-009 gnt_o  output  2  one-hot grant, combinational from current-cycle inputs and state.
REQ-010 err_o  output  1  one-cycle pulse: previous grant carried an invalid interval.
REQ-011 lookup_valid_i  input  1  lookup strobe.
REQ-012 lookup_addr_i  input  AW  address to check.
REQ-013 lookup_valid_o  output  1  lookup result valid.
REQ-014 hit_o  output  1  address inside some valid interval.
REQ-015 hit_first_o  output  1  address equals start of some hitting valid interval.
REQ-016 count_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-017 full_o  output  1  count_o == DEPTH.

Function
REQ-018 Arbitration SHALL be round-robin over 2 requesters via 1-bit priority pointer; prio requester wins when both request.
REQ-019 After a grant to requester k, the pointer SHALL move to the other requester; no grant leaves pointer unchanged.
REQ-020 Requester SHALL hold req and interval stable until granted; gnt_o is a single-cycle pulse; at most one grant per cycle.
REQ-021 When clr_i=1, gnt_o SHALL be 0; on that edge all entries invalid, write pointer 0, count 0, pointer unchanged.
REQ-022 Granted interval with start > end SHALL NOT be written; err_o=1 in next cycle only.
REQ-023 Granted interval equal (start and end) to an existing valid entry SHALL NOT be written; no pointer/count change, no error.
REQ-024 Otherwise entry[wr_ptr] SHALL be loaded and marked valid at the grant edge; wr_ptr increments modulo DEPTH.
REQ-025 count SHALL increment on each write and saturate at DEPTH; when full, a write overwrites the oldest entry (entry at wr_ptr).
REQ-026 Lookup SHALL have 1-cycle latency: lookup_valid_o = lookup_valid_i registered.
REQ-027 Lookup SHALL compare against table contents before any same-edge write or clear; hit condition unsigned start <= addr <= end.
REQ-028 hit_o and hit_first_o SHALL be 0 whenever lookup_valid_o is 0.
REQ-029 Single-address interval (start == end) SHALL be legal; both hit and hit_first on that address.
REQ-030 Entries SHALL be readable only through lookup; no other table output.

Reset
REQ-031 On rst_ni low, asynchronously: all entries invalid, wr_ptr 0, count 0, prio pointer 0, err_o 0, lookup_valid_o 0, hit_o 0, hit_first_o 0.
REQ-032 gnt_o SHALL be 0 while rst_ni low; reset mid-request discards the request, requester must re-present it.

Verification
REQ-033 Both req_i=11 for 4 cycles after reset, intervals held -> gnt_o 01,10,01,10 sequence if requesters re-raise; count_o reaches 2 after first two writes.
REQ-034 Write [0x1000,0x1020], lookup 0x1000 -> next cycle hit_o=1, hit_first_o=1; lookup 0x1021 -> hit_o=0.
REQ-035 Request start=0x2000 end=0x1FFF -> grant, err_o=1 next cycle, count_o unchanged, lookup 0x2000 misses.
REQ-036 DEPTH=8: write 9 distinct intervals -> full_o=1, count_o=8, first interval misses, ninth hits.
REQ-037 Write and clr_i same cycle as lookup of existing entry -> lookup hits, no grant, next cycle count_o=0 and same lookup misses.
REQ-038 Duplicate [0x3000,0x3004] written twice -> count_o=1, err_o stays 0.
